// File: rtl/bin2bcd_n_pkg.sv
// bin2bcd_n_pkg: FSM state encoding and BCD digit width shared by the converter files
package bin2bcd_n_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int DIG_W = 4;
endpackage

// File: rtl/bin2bcd_n_adj3.sv
// bin2bcd_n_adj3: one BCD digit pre-shift correction (add 3 when digit >= 5)
module bin2bcd_n_adj3
    import bin2bcd_n_pkg::*;
(
    input  logic [DIG_W-1:0] i_d,
    output logic [DIG_W-1:0] o_d
);
    assign o_d = (i_d >= 4'd5) ? i_d + 4'd3 : i_d;
endmodule

// File: rtl/bin2bcd_n.sv
// bin2bcd_n: sequential shift-and-add-3 binary to BCD converter with start/ready/done_tick
// handshake; BIN2BCD_SIGNED_EN treats bin as two's complement and adds the sign port
module bin2bcd_n
    import bin2bcd_n_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4,
    parameter int CNT_W  = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      ready,
    output logic                      done_tick,
    output logic [DIGITS*DIG_W-1:0]   bcd,
`ifdef BIN2BCD_SIGNED_EN
    output logic                      overflow,
    output logic                      sign
`else
    output logic                      overflow
`endif
);
    localparam int BW = DIGITS * DIG_W;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [BIN_W-1:0] r_sh, w_mag;
    logic [BW-1:0]    r_dig, w_adj, w_dig, r_bcd;
    logic             r_ovf, r_ovf_o, w_out, w_go, w_last;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bin2bcd_n_adj3 u_adj (
            .i_d(r_dig[i*DIG_W +: DIG_W]),
            .o_d(w_adj[i*DIG_W +: DIG_W])
        );
    end

    // Adjusted digits and shift register move left as one word; the top bit falls out
    assign {w_out, w_dig} = {w_adj, r_sh[BIN_W-1]};
    assign w_go   = (r_state == IDLE) && start;
    assign w_last = (r_state == OP) && (r_cnt == CNT_W'(1));

`ifdef BIN2BCD_SIGNED_EN
    logic r_neg, r_sign;
    assign w_mag = bin[BIN_W-1] ? -bin : bin;
    assign sign  = r_sign;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_neg  <= 1'b0;
            r_sign <= 1'b0;
        end else begin
            r_neg  <= w_go ? bin[BIN_W-1] : r_neg;
            r_sign <= w_last ? r_neg : r_sign;
        end
    end
`else
    assign w_mag = bin;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = IDLE;
        w_next = (r_state == IDLE) ? (start ? OP : IDLE) :
                 (r_state == OP)   ? (w_last ? DONE : OP) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_sh    <= '0;
            r_dig   <= '0;
            r_ovf   <= 1'b0;
            r_bcd   <= '0;
            r_ovf_o <= 1'b0;
        end else if (w_go) begin
            r_cnt <= CNT_W'(BIN_W);
            r_sh  <= w_mag;
            r_dig <= '0;
            r_ovf <= 1'b0;
        end else if (r_state == OP) begin
            r_cnt <= r_cnt - CNT_W'(1);
            r_sh  <= {r_sh[BIN_W-2:0], 1'b0};
            r_dig <= w_dig;
            r_ovf <= r_ovf | w_out;
            if (w_last) begin
                r_bcd   <= w_dig;
                r_ovf_o <= r_ovf | w_out;
            end
        end
    end

    assign ready     = (r_state == IDLE);
    assign done_tick = (r_state == DONE);
    assign bcd       = r_bcd;
    assign overflow  = r_ovf_o;
endmodule

// File: tb/tb_bin2bcd_n.sv
// tb_bin2bcd_n: table-driven check of bin2bcd_n at BIN_W=14, DIGITS=4
module tb_bin2bcd_n;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [13:0] bin;
    logic        ready, done_tick, overflow;
    logic [15:0] bcd;
    logic        sign;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    bin2bcd_n #(.BIN_W(14), .DIGITS(4), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .ready(ready), .done_tick(done_tick), .bcd(bcd),
`ifdef BIN2BCD_SIGNED_EN
        .overflow(overflow), .sign(sign)
`else
        .overflow(overflow)
`endif
    );
`ifndef BIN2BCD_SIGNED_EN
    assign sign = 1'b0;
`endif

    typedef struct {
        logic [13:0] b;
        logic [15:0] e;
        logic        o;
        logic        s;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one conversion and wait for done_tick; lat counts cycles after the start edge
    task automatic run(input logic [13:0] b, output int lat);
        @(negedge clk);
        bin = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        bin = 14'h1555;
        chk("ready_low_in_op", ready, 0);
        lat = 1;
        while (!done_tick && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        vec_t vecs[$];
        int   lat, cnt;
        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
`ifdef BIN2BCD_SIGNED_EN
        vecs = '{
            '{14'd0,    16'h0000, 1'b0, 1'b0},
            '{14'h3FFF, 16'h0001, 1'b0, 1'b1},
            '{14'h2000, 16'h8192, 1'b0, 1'b1},
            '{14'd1234, 16'h1234, 1'b0, 1'b0},
            '{14'd8191, 16'h8191, 1'b0, 1'b0},
            '{14'h3FD6, 16'h0042, 1'b0, 1'b1}
        };
`else
        vecs = '{
            '{14'd0,     16'h0000, 1'b0, 1'b0},
            '{14'd9999,  16'h9999, 1'b0, 1'b0},
            '{14'd1234,  16'h1234, 1'b0, 1'b0},
            '{14'd16383, 16'h6383, 1'b1, 1'b0},
            '{14'd42,    16'h0042, 1'b0, 1'b0},
            '{14'd10000, 16'h0000, 1'b1, 1'b0},
            '{14'd8192,  16'h8192, 1'b0, 1'b0},
            '{14'd1,     16'h0001, 1'b0, 1'b0}
        };
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", ready, 1);
        chk("rst_done", done_tick, 0);
        chk("rst_bcd", bcd, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_sign", sign, 0);

        foreach (vecs[i]) begin
            run(vecs[i].b, lat);
            chk("latency", lat, 15);
            chk("bcd", bcd, vecs[i].e);
            chk("ovf", overflow, vecs[i].o);
`ifdef BIN2BCD_SIGNED_EN
            chk("sign", sign, vecs[i].s);
`endif
            @(negedge clk);
            chk("done_one_cycle", done_tick, 0);
            chk("ready_after", ready, 1);
            chk("bcd_hold", bcd, vecs[i].e);
        end

        // start pulsed while busy must be ignored
        @(negedge clk);
        bin = 14'd1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        bin = 14'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!done_tick && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("midop_done_seen", done_tick, 1);
        chk("midop_bcd", bcd, 16'h1234);
        @(negedge clk);
        chk("midop_not_queued", ready, 1);
        repeat (3) @(negedge clk);
        chk("midop_no_second", ready, 1);

        // reset mid-conversion abandons it
        bin = 14'd4321;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_ready", ready, 1);
        chk("midrst_bcd", bcd, 0);
        chk("midrst_ovf", overflow, 0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            cnt += done_tick ? 1 : 0;
        end
        chk("midrst_no_done", cnt, 0);

        // start held high launches conversions back-to-back
        bin = 14'd7;
        start = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            cnt += done_tick ? 1 : 0;
        end
        start = 1'b0;
        chk("b2b_done_count", cnt, 2);
        lat = 0;
        while (!done_tick && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_drain", done_tick, 1);
        chk("b2b_bcd", bcd, 16'h0007);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
